fp_seq_mul: RTL

Parametrised sequential IEEE-754-style floating-point multiplier, the next generation of the team's single-precision sequential FP multiplier. It adds generic exponent and mantissa widths, a valid/ready handshake on both sides, and round-to-nearest-even. It also adds full special-value handling (zero, infinity, NaN) and IEEE exception flags. It sits behind the operand registers of the multiplier datapath and forms the mantissa product with an internal shift-add loop, one partial product per cycle.

---
 rtl/fp_seq_mul_if.sv | 32 +++
 rtl/fp_seq_mul.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_seq_mul_if.sv
// Handshake bundle for the sequential FP multiplier.
// Operand side in, product and exception flags out.
interface fp_seq_mul_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         overflow;
  logic         underflow;
  logic         invalid;
  logic         inexact;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result,
    input  overflow, underflow, invalid, inexact
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result,
    output overflow, underflow, invalid, inexact
  );
endinterface

// File: rtl/fp_seq_mul.sv
// Sequential IEEE-style FP multiplier: shift-add mantissa loop,
// RNE rounding, DAZ inputs, flush-to-zero, special values, flags.
module fp_seq_mul #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic        clk,
  input logic        rst,
  fp_seq_mul_if.slave bus
);
  localparam int M   = MAN_W + 1;
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int CW  = $clog2(M);
  localparam int EW2 = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW2-1:0] EMAX_S =
    EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE_S = EW2'(1);
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, MUL, NORM, DONE
  } state_t;

  state_t          state;
  logic [W-1:0]    ra;
  logic [W-1:0]    rb;
  logic [2*M-1:0]  acc;
  logic [CW-1:0]   cnt;

  logic             sa, sb, sr;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;

  assign sa = ra[W-1];
  assign sb = rb[W-1];
  assign ea = ra[W-2:MAN_W];
  assign eb = rb[W-2:MAN_W];
  assign fa = ra[MAN_W-1:0];
  assign fb = rb[MAN_W-1:0];
  assign sr = sa ^ sb;

  logic            a_nan, b_nan, a_inf, b_inf;
  logic            a_zero, b_zero;

  assign a_nan  = (ea == EONES) && (fa != '0);
  assign b_nan  = (eb == EONES) && (fb != '0);
  assign a_inf  = (ea == EONES) && (fa == '0);
  assign b_inf  = (eb == EONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  logic [M-1:0]    sig_b;
  logic [2*M-1:0]  pp;
  logic [2*M-1:0]  norm;
  logic [M-1:0]    keep;
  logic            hi, guard, sticky, rnd;
  logic [M:0]      sum;
  logic signed [EW2-1:0] e0;
  logic            ovf, unf;
  logic [MAN_W-1:0] frac_n;

  logic [W-1:0]    n_res;
  logic            n_ovf, n_unf, n_inv, n_inx;

  // Partial product, normalise and round from the accumulator
  always_comb begin
    sig_b  = {1'b1, fb};
    pp     = '0;
    if (sig_b[cnt])
      pp = {{M{1'b0}}, 1'b1, fa} << cnt;
    hi     = acc[2*M-1];
    norm   = hi ? acc : (acc << 1);
    keep   = norm[2*M-1:M];
    guard  = norm[M-1];
    sticky = |norm[M-2:0];
    rnd    = guard & (sticky | keep[0]);
    sum    = {1'b0, keep} + (M+1)'(rnd);
    e0     = EW2'(ea) + EW2'(eb) - EW2'(BIAS)
           + EW2'(hi) + EW2'(sum[M]);
    ovf    = (e0 >= EMAX_S);
    unf    = (e0 < ONE_S);
    frac_n = sum[M] ? '0 : sum[MAN_W-1:0];
  end

  // Special-value priority and range handling
  always_comb begin
    n_res = '0;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    n_inv = 1'b0;
    n_inx = 1'b0;
    if (a_nan | b_nan) begin
      n_res = QNAN;
    end else if ((a_inf & b_zero) | (a_zero & b_inf)) begin
      n_res = QNAN;
      n_inv = 1'b1;
    end else if (a_inf | b_inf) begin
      n_res = {sr, EONES, {MAN_W{1'b0}}};
    end else if (a_zero | b_zero) begin
      n_res = {sr, {(W-1){1'b0}}};
    end else if (ovf) begin
      n_res = {sr, EONES, {MAN_W{1'b0}}};
      n_ovf = 1'b1;
      n_inx = 1'b1;
    end else if (unf) begin
      n_res = {sr, {(W-1){1'b0}}};
      n_unf = 1'b1;
      n_inx = 1'b1;
    end else begin
      n_res = {sr, e0[EXP_W-1:0], frac_n};
      n_inx = guard | sticky;
    end
  end

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ra            <= '0;
      rb            <= '0;
      acc           <= '0;
      cnt           <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
      bus.invalid   <= 1'b0;
      bus.inexact   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ra           <= bus.a;
            rb           <= bus.b;
            acc          <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            state        <= MUL;
          end
        end
        MUL: begin
          acc <= acc + pp;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(M-1))
            state <= NORM;
        end
        NORM: begin
          bus.result    <= n_res;
          bus.overflow  <= n_ovf;
          bus.underflow <= n_unf;
          bus.invalid   <= n_inv;
          bus.inexact   <= n_inx;
          bus.out_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
